// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset (lw, sw, R/I-type ALU, branches, jal, lui).
// Sequences fetch/decode/execute/writeback and drives the datapath selects and enables.
module multicycle_ctrl #(
    parameter int TRAP_ON_SRA = 1,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  alu_res0,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  retire,
    output logic                  illegal
);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(4'b0011);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(4'b0100);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(4'b0101);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4'b0111);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4'b1000);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_sra;
    logic   w_taken;

    function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // Arithmetic right shifts are unsupported by the datapath unless treated as SRL.
    assign w_sra = (funct3 == 3'b101) && funct7b5 && (TRAP_ON_SRA != 0);

    always_comb begin
        case (funct3)
            3'b000:        w_taken = zero;
            3'b001:        w_taken = !zero;
            3'b100, 3'b110: w_taken = alu_res0;
            3'b101, 3'b111: w_taken = !alu_res0;
            default:       w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;

    always_comb begin
        case (op)
            7'b0100011: imm_src = 3'b001;
            7'b1100011: imm_src = 3'b010;
            7'b1101111: imm_src = 3'b011;
            7'b0110111: imm_src = 3'b100;
            default:    imm_src = 3'b000;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        retire     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jal target into ALUOut while dispatching.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = w_sra ? S_TRAP : S_EXECR;
                    7'b0010011: w_next = w_sra ? S_TRAP : S_EXECI;
                    7'b1100011: w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    7'b1101111: w_next = S_JAL;
                    7'b0110111: w_next = S_LUI;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_op(funct3, funct7b5);
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_op(funct3, 1'b0);
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                pc_write  = w_taken;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus queues the expected control word per cycle,
// a monitor pops and compares it against the DUT outputs on the falling edge.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       alu_res0;
    logic       mem_ready;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       retire;
    logic       illegal;

    multicycle_ctrl #(.TRAP_ON_SRA(1), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .alu_res0(alu_res0), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .retire(retire), .illegal(illegal)
    );

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011;
    localparam logic [3:0] SLL = 4'b0100, SLT = 4'b0101, SRL = 4'b0110, SLTU = 4'b0111;
    localparam logic [3:0] XOR_ = 4'b1000;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Field order: alu_ctrl, src_a, src_b, result_src, imm_src, adr_src,
    // ir_write, pc_write, reg_write, mem_write, retire, illegal.
    function automatic logic [19:0] C(input logic [3:0] a, input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [2:0] im, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic mw, input logic ret, input logic ill);
        return {a, sa, sb, rs, im, adr, irw, pcw, rw, mw, ret, ill};
    endfunction

    function automatic logic [19:0] F(input logic [2:0] im);
        return C(ADD, 2'b00, 2'b10, 2'b10, im, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] FS(input logic [2:0] im);
        return C(ADD, 2'b00, 2'b10, 2'b10, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] D(input logic [2:0] im);
        return C(ADD, 2'b01, 2'b01, 2'b00, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [19:0] WB(input logic [2:0] im);
        return C(ADD, 2'b00, 2'b00, 2'b00, im, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [19:0] Z(input logic [2:0] im, input logic ill);
        return C(ADD, 2'b00, 2'b00, 2'b00, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
    endfunction

    task automatic step(input string nm, input logic [19:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input logic [2:0] im);
        rst_n = 1'b0;
        step("reset_asserted", Z(im, 1'b0));
        rst_n = 1'b1;
        step("idle", Z(im, 1'b0));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e   = q.pop_front();
            act = {alu_ctrl, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
                   ir_write, pc_write, reg_write, mem_write, retire, illegal};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h", e.nm, act, e.v);
            end
        end
    end

    logic [3:0] itab [8];
    logic [2:0] bf3  [4];
    logic       bz   [4];
    logic       br0  [4];
    logic [3:0] balu [4];
    logic       bpc  [4];

    initial begin
        itab = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
        bf3  = '{3'b000, 3'b001, 3'b110, 3'b101};
        bz   = '{1'b1, 1'b1, 1'b0, 1'b0};
        br0  = '{1'b0, 1'b0, 1'b1, 1'b1};
        balu = '{SUB, SUB, SLTU, SLT};
        bpc  = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
        zero = 1'b0; alu_res0 = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_state", Z(3'b000, 1'b0));
        rst_n = 1'b1;
        step("idle", Z(3'b000, 1'b0));

        // R-type SUB
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        step("r_fetch", F(3'b000));
        step("r_decode", D(3'b000));
        step("execr_sub", C(SUB, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("r_aluwb", WB(3'b000));

        // lw with stalled fetch and stalled MEMREAD
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b0;
        step("lw_fetch_stall", FS(3'b000));
        step("lw_fetch_stall", FS(3'b000));
        mem_ready = 1'b1;
        step("lw_fetch", F(3'b000));
        mem_ready = 1'b0;
        step("lw_decode", D(3'b000));
        step("lw_memadr", C(ADD, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            step("lw_memread", C(ADD, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        mem_ready = 1'b1;
        step("lw_memwb", C(ADD, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));

        // Branch sweep
        for (int i = 0; i < 4; i++) begin
            op = 7'b1100011; funct3 = bf3[i]; zero = bz[i]; alu_res0 = br0[i];
            step("br_fetch", F(3'b010));
            step("br_decode", D(3'b010));
            step("br_exec", C(balu[i], 2'b10, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, bpc[i], 1'b0, 1'b0, 1'b1, 1'b0));
        end
        zero = 1'b0; alu_res0 = 1'b0;

        // I-type sweep, plus funct3 000 with funct7b5 set (still ADD)
        for (int i = 0; i < 9; i++) begin
            op = 7'b0010011; funct3 = 3'(i % 8); funct7b5 = (i == 8);
            step("i_fetch", F(3'b000));
            step("i_decode", D(3'b000));
            step("execi", C(itab[i % 8], 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            step("i_aluwb", WB(3'b000));
        end
        funct7b5 = 1'b0;

        // jal and lui
        op = 7'b1101111;
        step("jal_fetch", F(3'b011));
        step("jal_decode", D(3'b011));
        step("jal_exec", C(ADD, 2'b01, 2'b10, 2'b00, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step("jal_aluwb", WB(3'b011));
        op = 7'b0110111;
        step("lui_fetch", F(3'b100));
        step("lui_decode", D(3'b100));
        step("lui_exec", C(ADD, 2'b11, 2'b01, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("lui_aluwb", WB(3'b100));

        // sw completing after one wait cycle
        op = 7'b0100011; funct3 = 3'b010;
        step("sw_fetch", F(3'b001));
        step("sw_decode", D(3'b001));
        step("sw_memadr", C(ADD, 2'b10, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        mem_ready = 1'b0;
        step("sw_wait", C(ADD, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        mem_ready = 1'b1;
        step("sw_done", C(ADD, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));

        // sw interrupted by reset while mem_write is high
        step("sw2_fetch", F(3'b001));
        step("sw2_decode", D(3'b001));
        step("sw2_memadr", C(ADD, 2'b10, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        mem_ready = 1'b0;
        step("sw2_wait", C(ADD, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        rst_pulse(3'b001);
        mem_ready = 1'b1;

        // SRAI traps
        op = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
        step("srai_fetch", F(3'b000));
        step("srai_decode", D(3'b000));
        for (int i = 0; i < 3; i++) step("srai_trap", Z(3'b000, 1'b1));
        rst_pulse(3'b000);
        funct7b5 = 1'b0;

        // Undefined opcode traps, sticky for 20 cycles despite mem_ready activity
        op = 7'b1111111;
        step("bad_fetch", F(3'b000));
        step("bad_decode", D(3'b000));
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("bad_trap", Z(3'b000, 1'b1));
        end
        mem_ready = 1'b1;
        rst_pulse(3'b000);
        step("after_reset_fetch", F(3'b000));

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that drives the ALU's operation select and consumes its zero flag and result bit 0.
- Sequences fetch/decode/execute/writeback for an RV32I subset: lw, sw, R-type, I-type ALU, branches, jal, lui.
- Drives datapath mux selects and write enables, and stalls on a memory ready handshake.
- Traps illegal encodings into a sticky error state.

Parameters:
- TRAP_ON_SRA, 1: 1 = funct3 101 with funct7b5=1 (SRA/SRAI) goes to TRAP; 0 = executed as SRL.
- ALU_CTRL_W, 4: alu_ctrl width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- alu_res0  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_ready  in  1  memory access completes this cycle
- alu_ctrl  out  ALU_CTRL_W  ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SRL 0110, SLTU 0111, XOR 1000
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 ALUOut reg, 01 mem data, 10 ALU result
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- adr_src  out  1  0 PC, 1 ALUOut
- ir_write, pc_write, reg_write, mem_write  out  1 each  enables
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky, set in TRAP

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low. Reset puts the state register in IDLE and clears the illegal flop.
- IDLE outputs: all enables 0, all selects 0, alu_ctrl=ADD, retire=0, illegal=0. IDLE goes to FETCH after one cycle.
- Moore outputs are decoded from the state; alu_ctrl, imm_src and the branch decision also use the op/funct inputs, which are held stable from DECODE onward.
- imm_src is decoded from op in every state.
- Any state not listed below drives defaults: enables 0, selects 00, alu_ctrl=ADD.

States and transitions:
- FETCH: adr_src=0, src_a=00, src_b=10, ADD, result_src=10; ir_write=pc_write=mem_ready. Stay while !mem_ready, else go to DECODE.
- DECODE: src_a=01, src_b=01, ADD (branch/jal target into ALUOut). Dispatch on op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - else -> TRAP
- MEMADR: src_a=10, src_b=01, ADD. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adr_src=1. Stay while !mem_ready, else go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready. On mem_ready: retire=1, go to FETCH.
- EXECR: src_a=10, src_b=00. alu_ctrl by funct3:
  - 000: SUB if funct7b5 else ADD
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND
  - Goes to ALUWB.
- EXECI: as EXECR with src_b=01; funct3 000 is always ADD. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Goes to FETCH.
- BRANCH: src_a=10, src_b=00, result_src=00.
  - alu_ctrl: SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111.
  - taken: beq=zero, bne=!zero, blt/bltu=alu_res0, bge/bgeu=!alu_res0.
  - pc_write=taken, retire=1. Goes to FETCH.
  - funct3 010/011 in DECODE go to TRAP instead.
- JAL: src_a=01, src_b=10, ADD, result_src=00, pc_write=1. Goes to ALUWB (writes PC+4).
- LUI: src_a=11, src_b=01, ADD. Goes to ALUWB.
- TRAP: illegal=1, all enables 0. Stays until reset.

Latencies (mem_ready=1 constantly): lw 5 cycles; R/I/sw/jal/lui 4; branch 3.

Boundary conditions:
- mem_ready low for N cycles extends FETCH/MEMREAD/MEMWRITE by N cycles with no duplicate pc_write.
- Reset asserted mid-instruction returns to IDLE immediately; no enable remains asserted.
- A mem_ready pulse in non-memory states is ignored.

Test Plan:
- Reset, then mem_ready=1, op=0110011 f3=000 f7b5=1 -> states IDLE, FETCH, DECODE, EXECR(alu_ctrl=0001), ALUWB(reg_write=1, retire=1) -> FETCH.
- lw (op 0000011) with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adr_src=1 throughout, then MEMWB result_src=01 reg_write=1.
- Branch sweep: beq zero=1 -> pc_write=1; bne zero=1 -> pc_write=0; bltu alu_res0=1 with alu_ctrl=0111 -> pc_write=1; bge alu_res0=1 -> pc_write=0.
- I-type sweep funct3 000..111, funct7b5=0 -> alu_ctrl 0000,0100,0101,0111,1000,0110,0011,0010; f3=101 with f7b5=1 and TRAP_ON_SRA=1 -> TRAP, illegal=1.
- op=1111111 -> TRAP. illegal stays 1 and all enables stay 0 for 20 cycles. rst_n low -> illegal=0, state IDLE.
- rst_n pulsed low during MEMWRITE with mem_write=1 -> mem_write drops in the same cycle; after release: IDLE then FETCH.
